pipeline_stall_ctrl: RTL and testbench

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

---
 rtl/pipeline_stall_ctrl.sv | 120 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller with a data-memory wait FSM.
// Freezes or bubbles the pipeline and counts the cycles the PC is held.
module pipeline_stall_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hd_bubble_i,
    input  logic             branch_taken_i,
    input  logic             mem_rd_i,
    input  logic             mem_wr_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             pipe_stall_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERR
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       acc;
    logic       in_err;
    logic       mstall;
    logic       hd_sel;
    logic       br_sel;

    // While reset is held the outputs behave as if the FSM were in RUN.
    assign in_err = ~rst_i & (state == ERR);
    assign acc    = mem_rd_i | mem_wr_i;
    assign mstall = (acc & ~mem_ack_i & ~in_err) | in_err;
    assign hd_sel = ~mstall & hd_bubble_i;
    assign br_sel = ~mstall & ~hd_bubble_i & branch_taken_i;

    assign mem_req_o = acc & ~in_err;
    assign mem_we_o  = mem_wr_i & mem_req_o;

    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        pipe_stall_o   = 1'b0;
        unique case (1'b1)
            mstall: begin
                pc_write_o    = 1'b0;
                if_id_write_o = 1'b0;
                pipe_stall_o  = 1'b1;
            end
            hd_sel: begin
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
                id_ex_bubble_o = 1'b1;
            end
            br_sel: begin
                if_id_flush_o = 1'b1;
            end
            default: begin
                pc_write_o    = 1'b1;
                if_id_write_o = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err_o <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (acc && !mem_ack_i) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack_i) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= ERR;
                        mem_err_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (!pc_write_o && stall_cnt_o != '1) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus
// random traffic compared against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int TO = 4;
    localparam int CW = 8;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          hd;
    logic          br;
    logic          rd;
    logic          wr;
    logic          ack;
    logic          pc_write;
    logic          if_id_write;
    logic          if_id_flush;
    logic          id_ex_bubble;
    logic          pipe_stall;
    logic          mem_req;
    logic          mem_we;
    logic          mem_err;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .TIMEOUT(TO),
        .CNT_W  (CW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .hd_bubble_i   (hd),
        .branch_taken_i(br),
        .mem_rd_i      (rd),
        .mem_wr_i      (wr),
        .mem_ack_i     (ack),
        .pc_write_o    (pc_write),
        .if_id_write_o (if_id_write),
        .if_id_flush_o (if_id_flush),
        .id_ex_bubble_o(id_ex_bubble),
        .pipe_stall_o  (pipe_stall),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_err_o     (mem_err),
        .stall_cnt_o   (stall_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: waiting flag, number of unacked wait cycles seen, error flag,
    // and the stall count as a plain integer.
    bit m_valid = 0;
    bit m_err   = 0;
    bit m_wait  = 0;
    int m_waits = 0;
    int m_scnt  = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive(bit r, bit h, bit b, bit d, bit w, bit a);
        rst = r;
        hd  = h;
        br  = b;
        rd  = d;
        wr  = w;
        ack = a;
    endtask

    task automatic tick();
        bit a_mem;
        bit e_err;
        bit e_ms;
        bit e_pc;
        bit e_req;
        @(negedge clk);
        a_mem = rd | wr;
        e_err = !rst && m_err;
        e_ms  = e_err || (a_mem && !ack);
        e_pc  = !e_ms && !hd;
        e_req = a_mem && !e_err;
        check("pc_write", 32'(pc_write), 32'(e_pc));
        check("if_id_write", 32'(if_id_write), 32'(e_pc));
        check("if_id_flush", 32'(if_id_flush), 32'(!e_ms && !hd && br));
        check("id_ex_bubble", 32'(id_ex_bubble), 32'(!e_ms && hd));
        check("pipe_stall", 32'(pipe_stall), 32'(e_ms));
        check("mem_req", 32'(mem_req), 32'(e_req));
        check("mem_we", 32'(mem_we), 32'(wr && e_req));
        if (m_valid) begin
            check("mem_err", 32'(mem_err), 32'(m_err));
            check("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
        end
        if (rst) begin
            m_valid = 1;
            m_err   = 0;
            m_wait  = 0;
            m_waits = 0;
            m_scnt  = 0;
        end else begin
            if (!e_pc && m_scnt < SAT) m_scnt++;
            if (m_err) begin
                m_err = 1;
            end else if (!m_wait) begin
                if (a_mem && !ack) begin
                    m_wait  = 1;
                    m_waits = 0;
                end
            end else if (ack) begin
                m_wait = 0;
            end else begin
                m_waits++;
                if (m_waits >= TO) begin
                    m_wait = 0;
                    m_err  = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    bit pend;
    bit prd;
    bit pwr;

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        #1;
        tick();
        drive(1, 1, 1, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        // zero-wait load
        drive(0, 0, 0, 1, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        // store acked after three stalled cycles
        repeat (3) begin
            drive(0, 0, 0, 0, 1, 0);
            tick();
        end
        drive(0, 0, 0, 0, 1, 1);
        tick();
        check("stall_cnt_after_store", 32'(stall_cnt), 32'd3);
        // hazard suppresses branch, then branch flushes
        drive(0, 1, 1, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 0, 0);
        tick();
        // branch held through a two-cycle memory wait
        repeat (2) begin
            drive(0, 0, 1, 1, 0, 0);
            tick();
        end
        drive(0, 0, 1, 1, 0, 1);
        tick();
        // illegal load+store still writes
        drive(0, 0, 0, 1, 1, 1);
        tick();
        // reset in the middle of a wait
        repeat (2) begin
            drive(0, 0, 0, 1, 0, 0);
            tick();
        end
        drive(1, 0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        // timeout into the error state, long enough to saturate the count
        repeat (TO + 1) begin
            drive(0, 0, 0, 1, 0, 0);
            tick();
        end
        check("mem_err_at_timeout", 32'(mem_err), 32'd1);
        repeat (SAT + 20) begin
            drive(0, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), 0, $urandom_range(0, 1));
            tick();
        end
        check("stall_cnt_sat", 32'(stall_cnt), 32'(SAT));
        drive(1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("err_cleared", 32'(mem_err), 32'd0);
        // random traffic: an access is held until acked or reset
        pend = 0;
        repeat (2000) begin
            bit r;
            bit a;
            r = ($urandom_range(0, 99) < 2);
            if (!pend && $urandom_range(0, 3) == 0) begin
                pend = 1;
                prd  = $urandom_range(0, 1);
                pwr  = !prd || ($urandom_range(0, 15) == 0);
            end
            a = pend && ($urandom_range(0, 2) == 0);
            drive(r, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  pend && prd, pend && pwr, a);
            if (a || r) pend = 0;
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
